// File: rtl/controller_pkg.sv
// Shared definitions for the controller stages: bridge FSM states, bus/counter
// widths and the config-bus register map.
package controller_pkg;

  localparam int DT_MAX   = 255;
  localparam int TO_MAX   = 255;
  localparam int ADDR_MAX = 4;

  localparam int DT_W   = $clog2(DT_MAX + 1);
  localparam int TO_W   = $clog2(TO_MAX + 1);
  localparam int DATA_W = $clog2(((DT_MAX > TO_MAX) ? DT_MAX : TO_MAX) + 1);
  localparam int ADDR_W = $clog2(ADDR_MAX + 1);

  localparam logic [ADDR_W-1:0] ADDR_DT  = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] ADDR_TO  = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] ADDR_CLR = ADDR_W'(7);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DEAD  = 3'd1,
    ON_P  = 3'd2,
    ON_N  = 3'd3,
    STOP  = 3'd4,
    FAULT = 3'd5
  } state_e;

  // Counter reload for a window of max(dt,1) cycles; the counter runs down to 0.
  function automatic logic [DT_W-1:0] dead_load(input logic [DT_W-1:0] dt);
    return (dt == '0) ? '0 : dt - DT_W'(1);
  endfunction

endpackage

// File: rtl/gate_sync.sv
// Two-flop synchroniser for asynchronous control inputs; resets to 0.
module gate_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/gate_drv.sv
// H-bridge gate driver: dead-time insertion, run gating, lost-feedback timeout and
// latched over-current shutdown. Optional macro GATE_FAULT_AUTOCLR_EN re-arms on run off-time.
module gate_drv
  import controller_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sgn_pre,
  input  logic              run,
  input  logic              ocd,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic              a_hi,
  output logic              b_lo,
  output logic              a_lo,
  output logic              b_hi,
  output logic              fault,
  output logic              timeout
);

  logic            run_s;
  logic            ocd_s;
  logic            clr;
  state_e          state_q, state_d;
  logic            target_q, target_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic [DT_W-1:0] dt_q, dt_d;
  logic [DT_W-1:0] dead_ld;
  logic [TO_W-1:0] hc_q, hc_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [TO_W:0]   hc_nxt;
  logic            gp_q, gp_d;
  logic            gn_q, gn_d;
  logic            fault_q, fault_d;
  logic            timeout_q, timeout_d;

  gate_sync u_run_sync (.clk(clk), .rst_n(rst_n), .d(run), .q(run_s));
  gate_sync u_ocd_sync (.clk(clk), .rst_n(rst_n), .d(ocd), .q(ocd_s));

  always_comb begin
    dt_d = dt_q;
    to_d = to_q;
    if (en && (addr == ADDR_DT)) dt_d = DT_W'(data);
    if (en && (addr == ADDR_TO)) to_d = TO_W'(data);
  end

  assign clr     = en && (addr == ADDR_CLR);
  assign dead_ld = dead_load(dt_q);
  assign hc_nxt  = {1'b0, hc_q} + (TO_W + 1)'(1);

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    hc_d      = hc_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (run_s && !fault_q) begin
          target_d = sgn_pre;
          cnt_d    = dead_ld;
          state_d  = DEAD;
        end
      end
      DEAD: begin
        // A feedback flip inside the window restarts it towards the new polarity.
        if (sgn_pre != target_q) begin
          target_d = sgn_pre;
          cnt_d    = dead_ld;
        end else if (cnt_q == '0) begin
          hc_d    = '0;
          state_d = target_q ? ON_P : ON_N;
        end else begin
          cnt_d = cnt_q - DT_W'(1);
        end
      end
      ON_P, ON_N: begin
        if (sgn_pre != target_q) begin
          cnt_d = dead_ld;
          if (run_s) begin
            target_d = sgn_pre;
            hc_d     = '0;
            state_d  = DEAD;
          end else begin
            state_d = STOP;
          end
        end else if ((to_q != '0) && (hc_nxt == {1'b0, to_q})) begin
          timeout_d = 1'b1;
          cnt_d     = dead_ld;
          state_d   = STOP;
        end else if (hc_q != '1) begin
          hc_d = hc_q + TO_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - DT_W'(1);
      end
      FAULT: begin
        if (clr && !ocd_s) state_d = IDLE;
`ifdef GATE_FAULT_AUTOCLR_EN
        else if (!run_s && !ocd_s) state_d = IDLE;
`else
`endif
      end
      default: state_d = IDLE;
    endcase
    // Over-current overrides every other transition, including a pending timeout.
    if (ocd_s) begin
      state_d   = FAULT;
      timeout_d = 1'b0;
    end
  end

  assign gp_d    = (state_d == ON_P);
  assign gn_d    = (state_d == ON_N);
  assign fault_d = (state_d == FAULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      target_q  <= 1'b0;
      cnt_q     <= '0;
      hc_q      <= '0;
      dt_q      <= '0;
      to_q      <= '0;
      gp_q      <= 1'b0;
      gn_q      <= 1'b0;
      fault_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      hc_q      <= hc_d;
      dt_q      <= dt_d;
      to_q      <= to_d;
      gp_q      <= gp_d;
      gn_q      <= gn_d;
      fault_q   <= fault_d;
      timeout_q <= timeout_d;
    end
  end

  assign a_hi    = gp_q;
  assign b_lo    = gp_q;
  assign a_lo    = gn_q;
  assign b_hi    = gn_q;
  assign fault   = fault_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_gate_drv.sv
// Scoreboard bench for gate_drv: each scenario queues the expected output vector
// {a_hi,b_lo,a_lo,b_hi,fault,timeout} per cycle and drains it against the DUT.
module tb_gate_drv;
  import controller_pkg::*;

  localparam logic [5:0] E_OFF = 6'b000000;
  localparam logic [5:0] E_P   = 6'b110000;
  localparam logic [5:0] E_N   = 6'b001100;
  localparam logic [5:0] E_F   = 6'b000010;
  localparam logic [5:0] E_T   = 6'b000001;

  logic              clk;
  logic              rst_n;
  logic              sgn_pre;
  logic              run;
  logic              ocd;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              en;
  logic              a_hi, b_lo, a_lo, b_hi, fault, timeout;
  logic [5:0]        outs;

  logic [5:0] sb[$];
  int         n_chk  = 0;
  int         n_fail = 0;

  gate_drv dut (
    .clk(clk), .rst_n(rst_n), .sgn_pre(sgn_pre), .run(run), .ocd(ocd),
    .data(data), .addr(addr), .en(en),
    .a_hi(a_hi), .b_lo(b_lo), .a_lo(a_lo), .b_hi(b_hi),
    .fault(fault), .timeout(timeout)
  );

  assign outs = {a_hi, b_lo, a_lo, b_hi, fault, timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] v, input int n);
    repeat (n) sb.push_back(v);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input int d);
    addr = a;
    data = DATA_W'(d);
    en   = 1'b1;
    cyc();
    en   = 1'b0;
    addr = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; ocd = 1'b0; en = 1'b0; sgn_pre = 1'b0;
    addr = '0; data = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    logic [5:0] e;
    push(E_OFF, 2);
    while (sb.size() != 0) begin
      cyc();
      e = sb.pop_front(); n_chk++;
      if (outs !== e) begin n_fail++; $display("FAIL reset_hold: got %b want %b", outs, e); end
    end
    rst_n = 1'b1;
    push(E_OFF, 2);
    while (sb.size() != 0) begin
      cyc();
      e = sb.pop_front(); n_chk++;
      if (outs !== e) begin n_fail++; $display("FAIL reset_release: got %b want %b", outs, e); end
    end
  endtask

  task automatic test_dead_time();
    logic [5:0] e;
    int i;
    do_reset();
    wr(ADDR_DT, 3);
    sgn_pre = 1'b1;
    run     = 1'b1;
    push(E_OFF, 5);
    push(E_P, 14);
    i = 0;
    while (sb.size() != 0) begin
      cyc(); i++;
      e = sb.pop_front(); n_chk++;
      if (outs !== e) begin n_fail++; $display("FAIL dt3_start cyc %0d: got %b want %b", i, outs, e); end
    end
    for (int k = 0; k < 4; k++) begin
      sgn_pre = ~sgn_pre;
      push(E_OFF, 3);
      push(sgn_pre ? E_P : E_N, 17);
      i = 0;
      while (sb.size() != 0) begin
        cyc(); i++;
        e = sb.pop_front(); n_chk++;
        if (outs !== e) begin
          n_fail++; $display("FAIL dt3_edge%0d cyc %0d: got %b want %b", k, i, outs, e);
        end
      end
    end
  endtask

  task automatic test_dt_zero();
    logic [5:0] e;
    int i;
    wr(ADDR_DT, 0);
    for (int k = 0; k < 2; k++) begin
      sgn_pre = ~sgn_pre;
      push(E_OFF, 1);
      push(sgn_pre ? E_P : E_N, 5);
      i = 0;
      while (sb.size() != 0) begin
        cyc(); i++;
        e = sb.pop_front(); n_chk++;
        if (outs !== e) begin
          n_fail++; $display("FAIL dt0_edge%0d cyc %0d: got %b want %b", k, i, outs, e);
        end
      end
    end
  endtask

  task automatic test_glitch();
    logic [5:0] e;
    int i;
    wr(ADDR_DT, 5);
    sgn_pre = 1'b0;
    push(E_OFF, 9);
    push(E_N, 6);
    i = 0;
    while (sb.size() != 0) begin
      cyc(); i++;
      e = sb.pop_front(); n_chk++;
      if (outs !== e) begin n_fail++; $display("FAIL glitch cyc %0d: got %b want %b", i, outs, e); end
      if (i == 2) sgn_pre = 1'b1;
      if (i == 4) sgn_pre = 1'b0;
    end
  endtask

  task automatic test_run_drop();
    logic [5:0] e;
    int i;
    run = 1'b0;
    push(E_N, 8);
    push(E_OFF, 11);
    push(E_P, 4);
    i = 0;
    while (sb.size() != 0) begin
      cyc(); i++;
      e = sb.pop_front(); n_chk++;
      if (outs !== e) begin n_fail++; $display("FAIL run_drop cyc %0d: got %b want %b", i, outs, e); end
      if (i == 8)  sgn_pre = 1'b1;
      if (i == 11) run = 1'b1;
    end
  endtask

  task automatic test_timeout();
    logic [5:0] e;
    int i;
    do_reset();
    wr(ADDR_DT, 2);
    wr(ADDR_TO, 10);
    sgn_pre = 1'b1;
    run     = 1'b1;
    push(E_OFF, 4); push(E_P, 10); push(E_T, 1);
    push(E_OFF, 4); push(E_P, 10); push(E_T, 1);
    i = 0;
    while (sb.size() != 0) begin
      cyc(); i++;
      e = sb.pop_front(); n_chk++;
      if (outs !== e) begin n_fail++; $display("FAIL timeout cyc %0d: got %b want %b", i, outs, e); end
    end
  endtask

  task automatic test_fault();
    logic [5:0] e;
    int i;
    do_reset();
    wr(ADDR_DT, 3);
    sgn_pre = 1'b1;
    run     = 1'b1;
    push(E_OFF, 5); push(E_P, 7); push(E_F, 5);
    push(E_OFF, 4); push(E_P, 5); push(E_F, 10);
`ifdef GATE_FAULT_AUTOCLR_EN
    push(E_F, 2); push(E_OFF, 4);
`else
    push(E_F, 6);
`endif
    i = 0;
    while (sb.size() != 0) begin
      cyc(); i++;
      e = sb.pop_front(); n_chk++;
      if (outs !== e) begin n_fail++; $display("FAIL fault cyc %0d: got %b want %b", i, outs, e); end
      case (i)
        10: ocd = 1'b1;
        11: ocd = 1'b0;
        17: begin addr = ADDR_CLR; en = 1'b1; end
        18: begin en = 1'b0; addr = '0; end
        24: ocd = 1'b1;
        28: begin addr = ADDR_CLR; en = 1'b1; end
        29: begin en = 1'b0; addr = '0; end
        32: ocd = 1'b0;
        36: run = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] e;
    int i;
    do_reset();
    wr(ADDR_DT, 1);
    sgn_pre = 1'b0;
    run     = 1'b1;
    push(E_OFF, 3);
    push(E_N, 4);
    i = 0;
    while (sb.size() != 0) begin
      cyc(); i++;
      e = sb.pop_front(); n_chk++;
      if (outs !== e) begin n_fail++; $display("FAIL async_rst_pre cyc %0d: got %b want %b", i, outs, e); end
    end
    #3;
    rst_n = 1'b0;
    #1;
    push(E_OFF, 1);
    e = sb.pop_front(); n_chk++;
    if (outs !== e) begin n_fail++; $display("FAIL async_rst_immediate: got %b want %b", outs, e); end
    cyc();
    rst_n = 1'b1;
    push(E_OFF, 4);
    push(E_N, 2);
    i = 0;
    while (sb.size() != 0) begin
      if (i > 0) cyc();
      i++;
      e = sb.pop_front(); n_chk++;
      if (outs !== e) begin n_fail++; $display("FAIL async_rst_post cyc %0d: got %b want %b", i, outs, e); end
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; ocd = 1'b0; en = 1'b0; sgn_pre = 1'b0;
    addr = '0; data = '0;
    test_reset();
    test_dead_time();
    test_dt_zero();
    test_glitch();
    test_run_drop();
    test_timeout();
    test_fault();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
